// File: rtl/bullcow_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bullcow_display_if : game-event update handshake and payload         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bullcow_display_if;
   logic       upd_valid;
   logic       upd_ready;
   logic [1:0] upd_kind;
   logic       upd_player;
   logic [2:0] bulls;
   logic [2:0] cows;

   modport master (
      output upd_valid, upd_kind, upd_player, bulls, cows,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_kind, upd_player, bulls, cows,
      output upd_ready
   );
endinterface
`default_nettype wire

// File: rtl/bullcow_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bullcow_display : Bulls & Cows message FSM and 8-digit 7-seg scanner |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bullcow_display #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned HOLD_CYCLES = 150000000,
   parameter int unsigned BLINK_DIV   = 25000000,
   parameter int unsigned WIN_BLINKS  = 4
) (
   input  wire logic        clock,
   input  wire logic        reset,
   bullcow_display_if.slave upd,
   input  wire logic [7:0]  points_j1,
   input  wire logic [7:0]  points_j2,
   output logic [7:0]       an,
   output logic [7:0]       dec_cat
);

   typedef enum logic [2:0] {
      SCORE   = 3'd0,
      RESULT  = 3'd1,
      ACCEPT  = 3'd2,
      INVALID = 3'd3,
      WIN     = 3'd4
   } state_t;

   localparam logic [7:0]  SEG_P        = 8'h31;
   localparam logic [7:0]  SEG_B        = 8'hC1;
   localparam logic [7:0]  SEG_C        = 8'hE5;
   localparam logic [7:0]  SEG_E        = 8'h61;
   localparam logic [7:0]  SEG_DASH     = 8'hFD;
   localparam logic [7:0]  SEG_BLANK    = 8'hFF;
   localparam int unsigned BLINK_PERIOD = 2 * BLINK_DIV;

   state_t      state;
   state_t      next_state;
   logic [1:0]  kind_reg;
   logic        player_reg;
   logic [2:0]  bulls_reg;
   logic [2:0]  cows_reg;
   logic [31:0] hold_cnt;
   logic [31:0] blink_cnt;
   logic [31:0] blink_num;
   logic [31:0] refresh_cnt;
   logic [2:0]  digit_idx;
   logic        accept;
   logic        in_message;
   logic        hold_done;
   logic        win_done;
   logic        win_off;
   logic [7:0]  player_seg;
   logic [7:0]  glyph;

   function automatic logic [7:0] hex_seg(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0: s = 8'h03;
         4'h1: s = 8'h9F;
         4'h2: s = 8'h25;
         4'h3: s = 8'h0D;
         4'h4: s = 8'h99;
         4'h5: s = 8'h49;
         4'h6: s = 8'h41;
         4'h7: s = 8'h1F;
         4'h8: s = 8'h01;
         4'h9: s = 8'h09;
         4'hA: s = 8'h11;
         4'hB: s = 8'hC1;
         4'hC: s = 8'h63;
         4'hD: s = 8'h85;
         4'hE: s = 8'h61;
         4'hF: s = 8'h71;
      endcase
      return s;
   endfunction

   // Counts above 4 cannot occur in a 4-digit game, so they render as a dash.
   function automatic logic [7:0] count_seg(input logic [2:0] v);
      return (v > 3'd4) ? SEG_DASH : hex_seg({1'b0, v});
   endfunction

   assign upd.upd_ready = (state != WIN);
   assign accept        = upd.upd_valid && (state != WIN);
   assign in_message    = (state == RESULT) || (state == ACCEPT) || (state == INVALID);
   assign hold_done     = (hold_cnt == HOLD_CYCLES - 1);
   assign win_done      = (blink_cnt == BLINK_PERIOD - 1) && (blink_num == WIN_BLINKS - 1);
   assign win_off       = (state == WIN) && (blink_cnt >= BLINK_DIV);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= SCORE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (accept) begin
         case (upd.upd_kind)
            2'd0:    next_state = RESULT;
            2'd1:    next_state = ACCEPT;
            2'd2:    next_state = INVALID;
            default: next_state = WIN;
         endcase
      end else if (in_message && hold_done) begin
         next_state = SCORE;
      end else if ((state == WIN) && win_done) begin
         next_state = SCORE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         kind_reg   <= 2'd0;
         player_reg <= 1'b0;
         bulls_reg  <= 3'd0;
         cows_reg   <= 3'd0;
         hold_cnt   <= 32'd0;
         blink_cnt  <= 32'd0;
         blink_num  <= 32'd0;
      end else if (accept) begin
         kind_reg   <= upd.upd_kind;
         player_reg <= upd.upd_player;
         bulls_reg  <= upd.bulls;
         cows_reg   <= upd.cows;
         hold_cnt   <= 32'd0;
         blink_cnt  <= 32'd0;
         blink_num  <= 32'd0;
      end else begin
         hold_cnt <= in_message ? hold_cnt + 32'd1 : 32'd0;
         if (state != WIN) begin
            blink_cnt <= 32'd0;
            blink_num <= 32'd0;
         end else if (blink_cnt == BLINK_PERIOD - 1) begin
            blink_cnt <= 32'd0;
            blink_num <= blink_num + 32'd1;
         end else begin
            blink_cnt <= blink_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         refresh_cnt <= 32'd0;
         digit_idx   <= 3'd0;
      end else if (refresh_cnt == REFRESH_DIV - 1) begin
         refresh_cnt <= 32'd0;
         digit_idx   <= digit_idx + 3'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 32'd1;
      end
   end

   // Message layout follows the captured kind; WIN reuses the RESULT layout.
   always_comb begin
      glyph      = SEG_BLANK;
      player_seg = hex_seg({3'b000, player_reg} + 4'd1);
      if (state == SCORE) begin
         case (digit_idx)
            3'd7:    glyph = SEG_P;
            3'd6:    glyph = hex_seg(4'h1);
            3'd5:    glyph = hex_seg(points_j1[7:4]);
            3'd4:    glyph = hex_seg(points_j1[3:0]);
            3'd3:    glyph = SEG_P;
            3'd2:    glyph = hex_seg(4'h2);
            3'd1:    glyph = hex_seg(points_j2[7:4]);
            default: glyph = hex_seg(points_j2[3:0]);
         endcase
      end else if (digit_idx == 3'd7) begin
         glyph = (kind_reg == 2'd2) ? SEG_E : SEG_P;
      end else if (digit_idx == 3'd6) begin
         glyph = player_seg;
      end else begin
         case (kind_reg)
            2'd1: glyph = SEG_BLANK;
            2'd2: glyph = SEG_DASH;
            default: begin
               case (digit_idx)
                  3'd4:    glyph = count_seg(bulls_reg);
                  3'd3:    glyph = SEG_B;
                  3'd1:    glyph = count_seg(cows_reg);
                  3'd0:    glyph = SEG_C;
                  default: glyph = SEG_BLANK;
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         an      <= 8'hFF;
         dec_cat <= 8'hFF;
      end else begin
         an      <= ~(8'd1 << digit_idx);
         dec_cat <= win_off ? SEG_BLANK : glyph;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bullcow_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bullcow_display : randomized scoreboard bench for bullcow_display |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bullcow_display;
   localparam int R = 4;
   localparam int H = 40;
   localparam int B = 6;
   localparam int N = 2;

   localparam int M_SCORE   = 0;
   localparam int M_RESULT  = 1;
   localparam int M_ACCEPT  = 2;
   localparam int M_INVALID = 3;
   localparam int M_WIN     = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] points_j1;
   logic [7:0] points_j2;
   logic [7:0] an;
   logic [7:0] dec_cat;

   bullcow_display_if bus();

   bullcow_display #(
      .REFRESH_DIV (R),
      .HOLD_CYCLES (H),
      .BLINK_DIV   (B),
      .WIN_BLINKS  (N)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .upd       (bus),
      .points_j1 (points_j1),
      .points_j2 (points_j2),
      .an        (an),
      .dec_cat   (dec_cat)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       ready;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   string hexsegs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   // Active-low segment byte {a..g,dp} built from the list of lit segments.
   function automatic logic [7:0] glyph(string segs);
      logic [7:0] v;
      v = 8'hFF;
      for (int i = 0; i < segs.len(); i++) v[7 - (int'(segs[i]) - 97)] = 1'b0;
      return v;
   endfunction

   function automatic logic [7:0] hexg(int n);
      return glyph(hexsegs[n]);
   endfunction

   function automatic logic [7:0] cntg(int n);
      return (n >= 5) ? glyph("g") : hexg(n);
   endfunction

   function automatic logic [63:0] model_row(int md, int pl, int bu, int co,
                                             logic [7:0] p1, logic [7:0] p2);
      logic [7:0] pg;
      logic [7:0] gp;
      pg = hexg(pl + 1);
      gp = glyph("abefg");
      case (md)
         M_SCORE:   return {gp, hexg(1), hexg(int'(p1[7:4])), hexg(int'(p1[3:0])),
                            gp, hexg(2), hexg(int'(p2[7:4])), hexg(int'(p2[3:0]))};
         M_ACCEPT:  return {gp, pg, {6{8'hFF}}};
         M_INVALID: return {hexg(14), pg, {6{glyph("g")}}};
         default:   return {gp, pg, 8'hFF, cntg(bu), hexg(11), 8'hFF, cntg(co), glyph("deg")};
      endcase
   endfunction

   // Reference model: time since reset picks the digit, time since the
   // last accepted event decides message expiry and blink phase.
   int cyc, mode, t, m_player, m_bulls, m_cows;

   always @(posedge clock) begin : model
      exp_t        e;
      logic [63:0] row;
      int          idx;
      if (reset) begin
         mode = M_SCORE; t = 0; cyc = 0;
         m_player = 0; m_bulls = 0; m_cows = 0;
         e.an = 8'hFF; e.seg = 8'hFF; e.ready = 1'b1;
      end else begin
         row  = model_row(mode, m_player, m_bulls, m_cows, points_j1, points_j2);
         idx  = (cyc / R) % 8;
         e.an = ~(8'd1 << idx);
         e.seg = (mode == M_WIN && (t % (2 * B)) >= B) ? 8'hFF : row[idx * 8 +: 8];
         cyc++;
         if (bus.upd_valid && mode != M_WIN) begin
            mode     = (bus.upd_kind == 2'd3) ? M_WIN : int'(bus.upd_kind) + 1;
            t        = 0;
            m_player = int'(bus.upd_player);
            m_bulls  = int'(bus.bulls);
            m_cows   = int'(bus.cows);
         end else if (mode != M_SCORE) begin
            t++;
            if ((mode == M_WIN) ? (t == 2 * B * N) : (t == H)) mode = M_SCORE;
         end
         e.ready = (mode != M_WIN);
      end
      sb.push_back(e);
   end

   task automatic check(string name, logic [7:0] got, logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %02h want %02h", name, $time, got, want);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("an", an, e.an);
         check("dec_cat", dec_cat, e.seg);
         check("upd_ready", {7'd0, bus.upd_ready}, {7'd0, e.ready});
      end
   end

   // Idle cycles scramble the payload lines to prove glyphs use captured fields.
   task automatic idle(int n);
      repeat (n) begin
         bus.upd_valid  = 1'b0;
         bus.upd_kind   = 2'($urandom_range(0, 3));
         bus.upd_player = 1'($urandom_range(0, 1));
         bus.bulls      = 3'($urandom_range(0, 7));
         bus.cows       = 3'($urandom_range(0, 7));
         @(negedge clock);
      end
   endtask

   task automatic offer(int kind, int player, int bu, int co);
      bus.upd_valid  = 1'b1;
      bus.upd_kind   = 2'(kind);
      bus.upd_player = 1'(player);
      bus.bulls      = 3'(bu);
      bus.cows       = 3'(co);
      @(negedge clock);
      bus.upd_valid  = 1'b0;
   endtask

   initial begin
      bus.upd_valid = 1'b0; bus.upd_kind = 2'd0; bus.upd_player = 1'b0;
      bus.bulls = 3'd0; bus.cows = 3'd0;
      points_j1 = 8'h12; points_j2 = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      idle(70);
      offer(0, 1, 2, 1);
      idle(50);
      offer(0, 0, 3, 0);
      idle(19);
      offer(2, 0, 0, 0);
      idle(50);
      offer(1, 1, 0, 0);
      idle(45);
      offer(3, 0, 4, 0);
      idle(3);
      offer(0, 1, 1, 1);
      idle(5);
      offer(2, 1, 0, 0);
      idle(25);
      offer(0, 1, 7, 5);
      idle(45);
      offer(3, 1, 4, 4);
      idle(9);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(20);
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            points_j1 = 8'($urandom);
            points_j2 = 8'($urandom);
         end
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            idle($urandom_range(1, 2));
            reset = 1'b0;
         end
         offer($urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 7));
         idle($urandom_range(0, 60));
      end
      idle(2);
      @(posedge clock);
      #1;
      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
